// File: rtl/seq_shift_rotate.sv
// Multi-cycle shift/rotate unit: up to STEP bit positions per clock.
// Start/busy/done handshake; result and cout are registered and held.
module seq_shift_rotate #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);
    localparam int AMT_W = $clog2(WIDTH);
    localparam logic [AMT_W:0] STEP_C  = (AMT_W+1)'(STEP);
    localparam logic [AMT_W:0] WIDTH_C = (AMT_W+1)'(WIDTH);

    localparam logic [2:0] OP_SHL  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHRA = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [2:0]         op_q, op_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [AMT_W-1:0]   n;
    logic               direct;
    logic               last;
    logic [AMT_W-1:0]   k;
    logic [AMT_W:0]     wsub;
    logic [AMT_W-1:0]   hi_idx;
    logic [AMT_W-1:0]   lo_idx;
    logic [2*WIDTH-1:0] dbl_l;
    logic [2*WIDTH-1:0] dbl_r;
    logic [WIDTH-1:0]   sh;
    logic               bit_out;
    logic               unused_amt;

    assign n          = amount[AMT_W-1:0];
    assign unused_amt = ^amount[WIDTH-1:AMT_W];
    assign direct     = (n == '0) || (op > OP_ROR);

    // One step moves k bits; the last step consumes whatever is left
    always_comb begin
        last    = ({1'b0, cnt_q} <= STEP_C);
        k       = last ? cnt_q : STEP_C[AMT_W-1:0];
        wsub    = WIDTH_C - {1'b0, k};
        hi_idx  = wsub[AMT_W-1:0];
        lo_idx  = k - AMT_W'(1);
        dbl_l   = {work_q, work_q} << k;
        dbl_r   = {work_q, work_q} >> k;
        sh      = work_q;
        bit_out = 1'b0;
        unique case (op_q)
            OP_SHL: begin
                sh      = work_q << k;
                bit_out = work_q[hi_idx];
            end
            OP_SHR: begin
                sh      = work_q >> k;
                bit_out = work_q[lo_idx];
            end
            OP_SHRA: begin
                sh      = $unsigned($signed(work_q) >>> k);
                bit_out = work_q[lo_idx];
            end
            OP_ROL: begin
                sh      = dbl_l[2*WIDTH-1:WIDTH];
                bit_out = work_q[hi_idx];
            end
            OP_ROR: begin
                sh      = dbl_r[WIDTH-1:0];
                bit_out = work_q[lo_idx];
            end
            default: begin
                sh      = work_q;
                bit_out = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = direct ? DONE : SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        work_d   = work_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = operand;
                    op_d   = op;
                    cnt_d  = n;
                    if (direct) begin
                        result_d = operand;
                        cout_d   = 1'b0;
                    end
                end
            end
            SHIFT: begin
                work_d = sh;
                cnt_d  = cnt_q - k;
                if (last) begin
                    result_d = sh;
                    cout_d   = bit_out;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            work_q   <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            work_q   <= work_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
endmodule

// File: tb/tb_seq_shift_rotate.sv
// Directed bench for seq_shift_rotate with STEP=1 and STEP=4 instances.
// Table-driven operations plus handshake and reset-abort sequences.
module tb_seq_shift_rotate;
    logic        clk = 1'b0;
    logic        clear_n;
    logic        start1, start4;
    logic [2:0]  op;
    logic [31:0] operand, amount;
    logic        busy1, done1, cout1;
    logic        busy4, done4, cout4;
    logic [31:0] result1, result4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_shift_rotate #(.WIDTH(32), .STEP(1)) dut1 (
        .clock(clk), .clear_n(clear_n), .start(start1), .op(op),
        .operand(operand), .amount(amount), .busy(busy1),
        .done(done1), .result(result1), .cout(cout1)
    );

    seq_shift_rotate #(.WIDTH(32), .STEP(4)) dut4 (
        .clock(clk), .clear_n(clear_n), .start(start4), .op(op),
        .operand(operand), .amount(amount), .busy(busy4),
        .done(done4), .result(result4), .cout(cout4)
    );

    typedef struct {
        bit          s4;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] amt;
        logic [31:0] res;
        logic        co;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic g_busy(input bit s4);
        return s4 ? busy4 : busy1;
    endfunction

    function automatic logic g_done(input bit s4);
        return s4 ? done4 : done1;
    endfunction

    function automatic logic [31:0] g_res(input bit s4);
        return s4 ? result4 : result1;
    endfunction

    function automatic logic g_cout(input bit s4);
        return s4 ? cout4 : cout1;
    endfunction

    // Wait for done; returns edges after the accept edge and busy cycles
    task automatic wait_done(input bit s4, output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (!g_done(s4) && cyc < 200) begin
            if (g_busy(s4)) bcnt++;
            @(negedge clk);
            cyc++;
        end
        if (g_busy(s4)) bcnt++;
    endtask

    task automatic run_op(input string nm, input vec_t v);
        int cyc, bcnt;
        @(negedge clk);
        op      = v.op;
        operand = v.a;
        amount  = v.amt;
        if (v.s4) start4 = 1'b1;
        else      start1 = 1'b1;
        @(negedge clk);
        start1  = 1'b0;
        start4  = 1'b0;
        operand = ~v.a;
        amount  = v.amt + 32'd3;
        op      = v.op ^ 3'b001;
        check({nm, " busy_after_accept"}, 32'(g_busy(v.s4)), 32'd1);
        wait_done(v.s4, cyc, bcnt);
        check({nm, " latency"}, cyc, v.lat);
        check({nm, " busy_cycles"}, bcnt, v.lat + 1);
        check({nm, " result"}, g_res(v.s4), v.res);
        check({nm, " cout"}, 32'(g_cout(v.s4)), 32'(v.co));
        @(negedge clk);
        check({nm, " done_pulse"}, 32'(g_done(v.s4)), 32'd0);
        check({nm, " busy_idle"}, 32'(g_busy(v.s4)), 32'd0);
        check({nm, " result_hold"}, g_res(v.s4), v.res);
    endtask

    initial begin
        int cyc, bcnt, pulses;
        vec_t v;

        vecs[0]  = '{0, 3'b011, 32'h8000_0001, 32'd4,  32'h0000_0018, 0, 4};
        vecs[1]  = '{0, 3'b010, 32'hF000_0000, 32'h24, 32'hFF00_0000, 0, 4};
        vecs[2]  = '{1, 3'b100, 32'h0000_00F1, 32'd9,  32'h7880_0000, 0, 3};
        vecs[3]  = '{0, 3'b000, 32'hFFFF_FFFF, 32'd0,  32'hFFFF_FFFF, 0, 0};
        vecs[4]  = '{0, 3'b111, 32'hFFFF_FFFF, 32'd5,  32'hFFFF_FFFF, 0, 0};
        vecs[5]  = '{0, 3'b000, 32'hC000_0000, 32'd1,  32'h8000_0000, 1, 1};
        vecs[6]  = '{0, 3'b001, 32'h0000_0003, 32'd2,  32'h0000_0000, 1, 2};
        vecs[7]  = '{0, 3'b010, 32'h8000_0001, 32'd1,  32'hC000_0000, 1, 1};
        vecs[8]  = '{0, 3'b011, 32'h8000_0000, 32'd1,  32'h0000_0001, 1, 1};
        vecs[9]  = '{0, 3'b100, 32'h0000_0001, 32'd1,  32'h8000_0000, 1, 1};
        vecs[10] = '{1, 3'b000, 32'h0000_000F, 32'd31, 32'h8000_0000, 1, 8};
        vecs[11] = '{1, 3'b010, 32'h8000_0000, 32'd5,  32'hFC00_0000, 0, 2};
        vecs[12] = '{1, 3'b100, 32'h1234_5678, 32'd4,  32'h8123_4567, 1, 1};
        vecs[13] = '{1, 3'b011, 32'h1234_5678, 32'd8,  32'h3456_7812, 0, 2};
        vecs[14] = '{1, 3'b101, 32'hA5A5_0F0F, 32'd31, 32'hA5A5_0F0F, 0, 0};

        clear_n = 1'b0;
        start1  = 1'b0;
        start4  = 1'b0;
        op      = 3'b000;
        operand = '0;
        amount  = '0;
        repeat (2) @(negedge clk);
        check("rst busy1", 32'(busy1), 32'd0);
        check("rst done1", 32'(done1), 32'd0);
        check("rst result1", result1, 32'd0);
        check("rst cout1", 32'(cout1), 32'd0);
        check("rst busy4", 32'(busy4), 32'd0);
        check("rst result4", result4, 32'd0);
        clear_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // start held high: only the first request and the first idle one count
        @(negedge clk);
        op      = 3'b001;
        operand = 32'h8000_0000;
        amount  = 32'd31;
        start1  = 1'b1;
        @(negedge clk);
        op      = 3'b000;
        operand = 32'h0000_0005;
        amount  = 32'd1;
        wait_done(1'b0, cyc, bcnt);
        check("hold first latency", cyc, 31);
        check("hold first result", result1, 32'h0000_0001);
        check("hold first cout", 32'(cout1), 32'd0);
        @(negedge clk);
        check("hold idle busy", 32'(busy1), 32'd0);
        check("hold idle done", 32'(done1), 32'd0);
        @(negedge clk);
        check("hold second accept", 32'(busy1), 32'd1);
        start1 = 1'b0;
        wait_done(1'b0, cyc, bcnt);
        check("hold second latency", cyc, 1);
        check("hold second result", result1, 32'h0000_000A);
        check("hold second cout", 32'(cout1), 32'd0);

        // reset pulse in the middle of a 10-step shift
        @(negedge clk);
        @(negedge clk);
        op      = 3'b000;
        operand = 32'h0000_0001;
        amount  = 32'd10;
        start1  = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (8) @(negedge clk);
        check("abort busy_before", 32'(busy1), 32'd1);
        clear_n = 1'b0;
        #1;
        check("abort busy", 32'(busy1), 32'd0);
        check("abort done", 32'(done1), 32'd0);
        check("abort result", result1, 32'd0);
        check("abort cout", 32'(cout1), 32'd0);
        #3;
        clear_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done1 || busy1) pulses++;
        end
        check("abort no_done", pulses, 0);
        v = '{0, 3'b000, 32'h0000_0001, 32'd10, 32'h0000_0400, 0, 10};
        run_op("after_abort", v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
